exe_result_buffer: RTL and testbench
====================================

EXE_RESULT_BUFFER -- requirements
Module: exe_result_buffer

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, datapath width.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  execute stage presents a result.
REQ-005 SHALL have port in_ready  out  1  buffer can accept this cycle.
REQ-006 SHALL have port in_res  in  WORD_LEN  ALU result.
REQ-007 SHALL have port in_nzcv  in  4  ALU flags, ordered {N,Z,C,V}.
REQ-008 SHALL have port in_s  in  1  instruction updates status flags.
REQ-009 SHALL have port in_dest  in  4  destination register index.
REQ-010 SHALL have port in_ctl  in  3  control bits, ordered {wb_en, mem_r, mem_w}.
REQ-011 SHALL have port in_st_val  in  WORD_LEN  store data.
REQ-012 SHALL have port flush  in  1  synchronous discard of all entries.
REQ-013 SHALL have port out_valid  out  1  head entry valid.
REQ-014 SHALL have port out_ready  in  1  memory stage consumes head.
REQ-015 SHALL have ports out_res, out_dest, out_ctl, out_st_val  out  WORD_LEN/4/3/WORD_LEN  head entry fields.
REQ-016 SHALL have port sr  out  4  status register {N,Z,C,V}.
REQ-017 SHALL have port cond  in  4  ARM condition code to evaluate.
REQ-018 SHALL have port cond_pass  out  1  cond satisfied by sr, combinational.
REQ-019 SHALL have port count  out  2  occupancy, 0..2.

Function
REQ-020 SHALL be a 2-entry in-order FIFO with states EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-021 SHALL define push = in_valid & in_ready & ~flush and pop = out_valid & out_ready & ~flush.
REQ-022 SHALL drive in_ready = (count != 2), independent of out_ready; FULL with pop gives in_ready 0 that cycle.
REQ-023 SHALL drive out_valid = (count != 0) and present the oldest entry on the out_* ports.
REQ-024 SHALL have a latency of one cycle: an entry pushed at edge t is visible on the outputs after edge t when EMPTY.
REQ-025 SHALL, on simultaneous push and pop in state ONE, keep count at 1 with the new entry at the head.
REQ-026 SHALL use 1-bit read and write pointers that wrap 1->0.
REQ-027 SHALL, on flush, set count, both pointers and out_valid to 0 at the next edge, ignoring any push and pop in that cycle.
REQ-028 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-029 SHALL never overwrite an unread entry; pushes in FULL are impossible because in_ready=0.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear count, pointers, all storage, and sr to 0, giving out_valid=0, in_ready=1 and out_* = 0.
REQ-031 SHALL discard any in-flight push or pop when reset asserts mid-operation.

Configuration
REQ-032 SHALL use macro STATUS_REG_EN.
REQ-033 SHALL, with STATUS_REG_EN defined, load sr <= in_nzcv on a push with in_s=1, with no update on flush or when in_s=0.
REQ-034 SHALL, with STATUS_REG_EN defined, evaluate cond_pass per ARM: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
REQ-035 SHALL, without STATUS_REG_EN, omit the status register, tie sr to 0 and cond_pass to 1, and ignore in_s and in_nzcv.

Verification
REQ-036 SHALL cover: reset, then push in_res=0x0000_0005 with out_ready=1 -> out_valid=1, out_res=5 one cycle later, then count=0.
REQ-037 SHALL cover: out_ready=0, push 0xA then 0xB -> count=2, in_ready=0; a third in_valid is not accepted; pops return 0xA then 0xB.
REQ-038 SHALL cover: count=1 with simultaneous push 0xC and pop -> count stays 1, head=0xC.
REQ-039 SHALL cover: count=2, flush=1 with in_valid=1 -> count=0, out_valid=0, sr unchanged.
REQ-040 SHALL cover (STATUS_REG_EN): push in_nzcv=0100, in_s=1 -> sr=0100, cond=0000 pass=1, cond=1100 pass=0; then push in_s=0, in_nzcv=1000 -> sr stays 0100.
REQ-041 SHALL cover: assert rst_n=0 mid-cycle while FULL -> outputs clear immediately; in_ready=1 after release.

Source files
------------

// File: rtl/exe_result_buffer.sv
// Two-entry in-order result buffer between execute and memory stages.
// Optional status register and ARM condition evaluation under STATUS_REG_EN.
module exe_result_buffer #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_LEN-1:0] in_res,
    input  logic [3:0]          in_nzcv,
    input  logic                in_s,
    input  logic [3:0]          in_dest,
    input  logic [2:0]          in_ctl,
    input  logic [WORD_LEN-1:0] in_st_val,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_LEN-1:0] out_res,
    output logic [3:0]          out_dest,
    output logic [2:0]          out_ctl,
    output logic [WORD_LEN-1:0] out_st_val,
    output logic [3:0]          sr,
    input  logic [3:0]          cond,
    output logic                cond_pass,
    output logic [1:0]          count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   wr_ptr_q, wr_ptr_d;
    logic   rd_ptr_q, rd_ptr_d;
    logic   push, pop;

    logic [WORD_LEN-1:0] res_q [2];
    logic [3:0]          dest_q [2];
    logic [2:0]          ctl_q [2];
    logic [WORD_LEN-1:0] st_q [2];

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign count     = state_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            state_d  = EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            unique case (state_q)
                EMPTY: if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop)      state_d = FULL;
                    else if (pop && !push) state_d = EMPTY;
                end
                FULL: if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Write slot is never the unread head when FULL, since push needs in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                res_q[i]  <= '0;
                dest_q[i] <= '0;
                ctl_q[i]  <= '0;
                st_q[i]   <= '0;
            end
        end else if (push) begin
            res_q[wr_ptr_q]  <= in_res;
            dest_q[wr_ptr_q] <= in_dest;
            ctl_q[wr_ptr_q]  <= in_ctl;
            st_q[wr_ptr_q]   <= in_st_val;
        end
    end

    assign out_res    = res_q[rd_ptr_q];
    assign out_dest   = dest_q[rd_ptr_q];
    assign out_ctl    = ctl_q[rd_ptr_q];
    assign out_st_val = st_q[rd_ptr_q];

`ifdef STATUS_REG_EN
    logic [3:0] sr_q;
    logic       f_n, f_z, f_c, f_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            sr_q <= 4'b0000;
        else if (push && in_s) sr_q <= in_nzcv;
    end

    assign sr = sr_q;
    assign {f_n, f_z, f_c, f_v} = sr_q;

    always_comb begin
        cond_pass = 1'b0;
        unique case (cond)
            4'b0000: cond_pass = f_z;
            4'b0001: cond_pass = !f_z;
            4'b0010: cond_pass = f_c;
            4'b0011: cond_pass = !f_c;
            4'b0100: cond_pass = f_n;
            4'b0101: cond_pass = !f_n;
            4'b0110: cond_pass = f_v;
            4'b0111: cond_pass = !f_v;
            4'b1000: cond_pass = f_c & !f_z;
            4'b1001: cond_pass = !f_c | f_z;
            4'b1010: cond_pass = (f_n == f_v);
            4'b1011: cond_pass = (f_n != f_v);
            4'b1100: cond_pass = !f_z & (f_n == f_v);
            4'b1101: cond_pass = f_z | (f_n != f_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{in_s, in_nzcv, cond};
    assign sr        = 4'b0000;
    assign cond_pass = 1'b1;
`endif

endmodule

// File: tb/tb_exe_result_buffer.sv
// Self-checking bench for exe_result_buffer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_exe_result_buffer;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_res;
    logic [3:0]   in_nzcv;
    logic         in_s;
    logic [3:0]   in_dest;
    logic [2:0]   in_ctl;
    logic [W-1:0] in_st_val;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic [3:0]   out_dest;
    logic [2:0]   out_ctl;
    logic [W-1:0] out_st_val;
    logic [3:0]   sr;
    logic [3:0]   cond;
    logic         cond_pass;
    logic [1:0]   count;

    exe_result_buffer #(.WORD_LEN(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_res(in_res),
        .in_nzcv(in_nzcv),
        .in_s(in_s),
        .in_dest(in_dest),
        .in_ctl(in_ctl),
        .in_st_val(in_st_val),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res(out_res),
        .out_dest(out_dest),
        .out_ctl(out_ctl),
        .out_st_val(out_st_val),
        .sr(sr),
        .cond(cond),
        .cond_pass(cond_pass),
        .count(count)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   dest;
        logic [2:0]   ctl;
        logic [W-1:0] st;
    } entry_t;

    entry_t     mq[$];
    logic [3:0] msr;
    int         checks = 0;
    int         errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_pass(logic [3:0] c, logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return !c[0];
        return base ^ c[0];
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: queue semantics straight from the buffer rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            msr = 4'b0000;
        end else if (flush) begin
            mq.delete();
        end else begin
            bit can_push, can_pop;
            entry_t e;
            can_push = in_valid && (mq.size() != 2);
            can_pop  = out_ready && (mq.size() != 0);
            if (can_pop) void'(mq.pop_front());
            if (can_push) begin
                e.res = in_res; e.dest = in_dest;
                e.ctl = in_ctl; e.st = in_st_val;
                mq.push_back(e);
`ifdef STATUS_REG_EN
                if (in_s) msr = in_nzcv;
`endif
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("m_count", count, mq.size());
        chk("m_in_ready", in_ready, mq.size() != 2);
        chk("m_out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("m_out_res", out_res, mq[0].res);
            chk("m_out_dest", out_dest, mq[0].dest);
            chk("m_out_ctl", out_ctl, mq[0].ctl);
            chk("m_out_st", out_st_val, mq[0].st);
        end
`ifdef STATUS_REG_EN
        chk("m_sr", sr, msr);
        chk("m_cond_pass", cond_pass, model_pass(cond, msr));
`else
        chk("m_sr", sr, 4'b0000);
        chk("m_cond_pass", cond_pass, 1'b1);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, logic [W-1:0] r, bit ordy);
        in_valid  = v;
        in_res    = r;
        in_dest   = r[3:0];
        in_ctl    = r[2:0];
        in_st_val = ~r;
        out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0);
        in_nzcv = 4'b0000;
        in_s    = 1'b0;
        flush   = 1'b0;
        cond    = 4'b1110;
        #2;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_res", out_res, 0);
        chk("rst_sr", sr, 0);
        step();
        step();
        rst_n = 1'b1;

        // Single push, one-cycle latency, then drained.
        drive(1, 32'h5, 1);
        step();
        drive(0, 0, 1);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_res", out_res, 32'h5);
        step();
        chk("lat_count0", count, 0);

        // Fill to FULL and block a third push.
        drive(1, 32'hA, 0);
        step();
        drive(1, 32'hB, 0);
        step();
        chk("full_count", count, 2);
        chk("full_in_ready", in_ready, 0);
        drive(1, 32'hD, 0);
        step();
        chk("full_hold_count", count, 2);
        chk("full_hold_res", out_res, 32'hA);
        drive(0, 0, 1);
        chk("pop_a", out_res, 32'hA);
        step();
        chk("pop_b", out_res, 32'hB);
        step();
        chk("drain_count", count, 0);

        // Push+pop in ONE keeps count with new entry at head.
        drive(1, 32'h1, 0);
        step();
        drive(1, 32'hC, 1);
        step();
        chk("pp_count", count, 1);
        chk("pp_head", out_res, 32'hC);
        drive(0, 0, 1);
        step();

`ifdef STATUS_REG_EN
        in_s = 1'b1; in_nzcv = 4'b0100;
        drive(1, 32'h7, 1);
        step();
        in_s = 1'b0; in_nzcv = 4'b1000;
        drive(1, 32'h8, 1);
        cond = 4'b0000;
        #1;
        chk("sr_load", sr, 4'b0100);
        chk("eq_pass", cond_pass, 1);
        cond = 4'b1100;
        #1;
        chk("gt_fail", cond_pass, 0);
        step();
        drive(0, 0, 1);
        chk("sr_keep", sr, 4'b0100);
        step();
`endif

        // Flush from FULL ignores the concurrent push; sr untouched.
        drive(1, 32'h21, 0);
        step();
        drive(1, 32'h22, 0);
        step();
        chk("pre_flush_count", count, 2);
        in_s = 1'b1; in_nzcv = 4'b1111;
        flush = 1'b1;
        drive(1, 32'h23, 1);
        step();
        flush = 1'b0; in_s = 1'b0;
        drive(0, 0, 0);
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
`ifdef STATUS_REG_EN
        chk("flush_sr", sr, 4'b0100);
`else
        chk("flush_sr", sr, 4'b0000);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) != 0, $urandom, $urandom_range(1));
            in_nzcv = 4'($urandom);
            in_s    = 1'($urandom);
            cond    = 4'($urandom);
            flush   = ($urandom_range(24) == 0);
            step();
        end
        flush = 1'b0;

        // Asynchronous reset while FULL.
        drive(1, 32'h31, 0);
        step();
        drive(1, 32'h32, 0);
        step();
        drive(1, 32'h33, 0);
        step();
        chk("arst_pre_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_res", out_res, 0);
        chk("arst_sr", sr, 0);
        drive(0, 0, 0);
        step();
        #3;
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_count", count, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
